// File: rtl/snax_csr_initiator.sv
// ============================================================================
// Module   : snax_csr_initiator
// Function : Turns write/read/poll commands into CSR requests and reports
//            read data or poll outcome on a result channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module snax_csr_initiator #(
    parameter int RegDataWidth = 32,
    parameter int RegAddrWidth = 32,
    parameter int TimeoutWidth = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [1:0]              cmd_op_i,
    input  logic [RegAddrWidth-1:0] cmd_addr_i,
    input  logic [RegDataWidth-1:0] cmd_data_i,
    input  logic [RegDataWidth-1:0] cmd_mask_i,
    input  logic [TimeoutWidth-1:0] cmd_timeout_i,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic [RegDataWidth-1:0] res_data_o,
    output logic                    res_err_o,
    output logic [RegAddrWidth-1:0] snax_req_addr_o,
    output logic [RegDataWidth-1:0] snax_req_data_o,
    output logic                    snax_req_write_o,
    output logic                    snax_req_valid_o,
    input  logic                    snax_req_ready_i,
    input  logic                    snax_rsp_valid_i,
    output logic                    snax_rsp_ready_o,
    input  logic [RegDataWidth-1:0] snax_rsp_data_i,
    output logic                    busy_o
);

    localparam logic [1:0] c_OP_WRITE   = 2'd0;
    localparam logic [1:0] c_OP_READ    = 2'd1;
    localparam logic [1:0] c_OP_POLL    = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ      = 2'd1,
        S_WAIT_RSP = 2'd2,
        S_RESULT   = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_ready_en;
    logic [1:0]              r_op;
    logic [RegAddrWidth-1:0] r_addr;
    logic [RegDataWidth-1:0] r_cmd_data;
    logic [RegDataWidth-1:0] r_mask;
    logic [TimeoutWidth-1:0] r_timeout;
    logic [TimeoutWidth-1:0] r_cnt;
    logic [RegDataWidth-1:0] r_res_data;
    logic                    r_res_err;

    logic w_accept;
    logic w_rsp_hs;
    logic w_match;
    logic w_retry;

    // Holds cmd_ready_o low while in reset and releases it on the first edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_ready_en <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ready_en <= 1'b1;
        end
    end

    assign w_match = ((snax_rsp_data_i & r_mask) == (r_cmp_data() & r_mask));

    function automatic logic [RegDataWidth-1:0] r_cmp_data();
        return r_cmd_data;
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_rsp_hs    = 1'b0;
        w_retry     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid_i && r_ready_en) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (cmd_op_i == 2'd3) ? S_RESULT : S_REQ;
                end
            end
            S_REQ: begin
                if (snax_req_ready_i) begin
                    w_state_nxt = (r_op == c_OP_WRITE) ? S_IDLE : S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                if (snax_rsp_valid_i) begin
                    w_rsp_hs = 1'b1;
                    if (r_op == c_OP_POLL && !w_match && (r_cnt < r_timeout)) begin
                        w_retry     = 1'b1;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_state_nxt = S_RESULT;
                    end
                end
            end
            S_RESULT: begin
                if (res_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_op       <= c_OP_WRITE;
            r_addr     <= '0;
            r_cmd_data <= '0;
            r_mask     <= '0;
            r_timeout  <= '0;
            r_cnt      <= '0;
            r_res_data <= '0;
            r_res_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op       <= cmd_op_i;
                r_addr     <= cmd_addr_i;
                r_cmd_data <= cmd_data_i;
                r_mask     <= cmd_mask_i;
                r_timeout  <= cmd_timeout_i;
                r_cnt      <= '0;
                if (cmd_op_i == 2'd3) begin
                    r_res_data <= '0;
                    r_res_err  <= 1'b1;
                end
            end
            if (w_rsp_hs) begin
                r_res_data <= snax_rsp_data_i;
                // A read always succeeds; a poll fails only when attempts run out.
                r_res_err  <= (r_op == c_OP_POLL) && !w_match;
                if (w_retry) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign cmd_ready_o      = r_ready_en && (r_state == S_IDLE);
    assign busy_o           = (r_state != S_IDLE);
    assign snax_req_valid_o = (r_state == S_REQ);
    assign snax_req_addr_o  = r_addr;
    assign snax_req_write_o = (r_op == c_OP_WRITE) && (r_state == S_REQ);
    assign snax_req_data_o  = (r_op == c_OP_WRITE) ? r_cmd_data : '0;
    assign snax_rsp_ready_o = (r_state == S_WAIT_RSP);
    assign res_valid_o      = (r_state == S_RESULT);
    assign res_data_o       = r_res_data;
    assign res_err_o        = r_res_err;

    logic w_unused;
    assign w_unused = (c_OP_READ == 2'd1);

endmodule

`default_nettype wire

// File: tb/tb_snax_csr_initiator.sv
// ============================================================================
// Module   : tb_snax_csr_initiator
// Function : Directed self-checking bench for snax_csr_initiator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_snax_csr_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic [31:0] cmd_mask = '0;
    logic [15:0] cmd_timeout = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        res_err;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        req_write;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic        rsp_ready;
    logic [31:0] rsp_data = '0;
    logic        busy;

    int n_checks = 0;
    int n_err    = 0;
    int n_reqs   = 0;
    int base;

    snax_csr_initiator dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .cmd_valid_i      (cmd_valid),
        .cmd_ready_o      (cmd_ready),
        .cmd_op_i         (cmd_op),
        .cmd_addr_i       (cmd_addr),
        .cmd_data_i       (cmd_data),
        .cmd_mask_i       (cmd_mask),
        .cmd_timeout_i    (cmd_timeout),
        .res_valid_o      (res_valid),
        .res_ready_i      (res_ready),
        .res_data_o       (res_data),
        .res_err_o        (res_err),
        .snax_req_addr_o  (req_addr),
        .snax_req_data_o  (req_data),
        .snax_req_write_o (req_write),
        .snax_req_valid_o (req_valid),
        .snax_req_ready_i (req_ready),
        .snax_rsp_valid_i (rsp_valid),
        .snax_rsp_ready_o (rsp_ready),
        .snax_rsp_data_i  (rsp_data),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (req_valid && req_ready) n_reqs <= n_reqs + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] mask, input logic [15:0] tmo);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_addr    = addr;
        cmd_data    = data;
        cmd_mask    = mask;
        cmd_timeout = tmo;
        step();
        cmd_valid   = 1'b0;
    endtask

    task automatic do_rsp(input logic [31:0] d);
        int k = 0;
        while (!rsp_ready && k < 20) begin
            step();
            k++;
        end
        check("rsp_ready_wait", {31'd0, rsp_ready}, 32'd1);
        rsp_valid = 1'b1;
        rsp_data  = d;
        step();
        rsp_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_req_valid", {31'd0, req_valid}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_rsp_ready", {31'd0, rsp_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Write with ready request channel
        req_ready = 1'b1;
        base = n_reqs;
        issue(2'd0, 32'h3, 32'hA5A5, 32'h0, 16'd0);
        check("wr_req_valid", {31'd0, req_valid}, 32'd1);
        check("wr_req_write", {31'd0, req_write}, 32'd1);
        check("wr_req_addr", req_addr, 32'h3);
        check("wr_req_data", req_data, 32'hA5A5);
        check("wr_busy", {31'd0, busy}, 32'd1);
        check("wr_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        step();
        check("wr_req_valid_done", {31'd0, req_valid}, 32'd0);
        check("wr_no_res", {31'd0, res_valid}, 32'd0);
        check("wr_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
        check("wr_req_count", n_reqs - base, 32'd1);

        // Read with three cycles of request backpressure
        req_ready = 1'b0;
        issue(2'd1, 32'hC, 32'hFFFF, 32'h0, 16'd0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) req_ready = 1'b1;
            check("rd_req_valid", {31'd0, req_valid}, 32'd1);
            check("rd_req_addr", req_addr, 32'hC);
            check("rd_req_write", {31'd0, req_write}, 32'd0);
            check("rd_req_data", req_data, 32'd0);
            step();
        end
        req_ready = 1'b0;
        check("rd_rsp_ready", {31'd0, rsp_ready}, 32'd1);
        check("rd_req_valid_off", {31'd0, req_valid}, 32'd0);
        rsp_valid = 1'b1;
        rsp_data  = 32'h1234;
        step();
        rsp_valid = 1'b0;
        check("rd_res_valid", {31'd0, res_valid}, 32'd1);
        check("rd_res_data", res_data, 32'h1234);
        check("rd_res_err", {31'd0, res_err}, 32'd0);
        check("rd_hs_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("rd_res_valid_off", {31'd0, res_valid}, 32'd0);
        check("rd_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);

        // Poll that matches on the third read
        req_ready = 1'b1;
        base = n_reqs;
        issue(2'd2, 32'h20, 32'h1, 32'h1, 16'd5);
        do_rsp(32'h0);
        do_rsp(32'h0);
        do_rsp(32'h3);
        check("poll_ok_res_valid", {31'd0, res_valid}, 32'd1);
        check("poll_ok_res_data", res_data, 32'h3);
        check("poll_ok_res_err", {31'd0, res_err}, 32'd0);
        check("poll_ok_reads", n_reqs - base, 32'd3);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // Poll that runs out of attempts
        base = n_reqs;
        issue(2'd2, 32'h24, 32'h8, 32'hF, 16'd2);
        do_rsp(32'h0);
        do_rsp(32'h0);
        do_rsp(32'h0);
        check("poll_to_res_valid", {31'd0, res_valid}, 32'd1);
        check("poll_to_res_err", {31'd0, res_err}, 32'd1);
        check("poll_to_res_data", res_data, 32'h0);
        check("poll_to_reads", n_reqs - base, 32'd3);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // Illegal op with result backpressure
        base = n_reqs;
        issue(2'd3, 32'h8, 32'h77, 32'h0, 16'd0);
        for (int i = 0; i < 4; i++) begin
            check("ill_res_valid", {31'd0, res_valid}, 32'd1);
            check("ill_res_err", {31'd0, res_err}, 32'd1);
            check("ill_res_data", res_data, 32'd0);
            check("ill_req_valid", {31'd0, req_valid}, 32'd0);
            step();
        end
        res_ready = 1'b1;
        check("ill_hs_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        step();
        res_ready = 1'b0;
        check("ill_res_valid_off", {31'd0, res_valid}, 32'd0);
        check("ill_no_reqs", n_reqs - base, 32'd0);
        check("ill_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);

        // Reset while a poll waits for its response
        issue(2'd2, 32'h30, 32'h8, 32'hF, 16'd3);
        step();
        check("mid_rsp_ready", {31'd0, rsp_ready}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_ready", {31'd0, rsp_ready}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("mid_rst_req_addr", req_addr, 32'd0);
        check("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("mid_post_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        rsp_valid = 1'b1;
        rsp_data  = 32'hDEAD;
        step();
        rsp_valid = 1'b0;
        check("stray_rsp_busy", {31'd0, busy}, 32'd0);
        check("stray_rsp_res_valid", {31'd0, res_valid}, 32'd0);
        issue(2'd1, 32'h4, 32'h0, 32'h0, 16'd0);
        check("fresh_req_addr", req_addr, 32'h4);
        do_rsp(32'h55AA);
        check("fresh_res_valid", {31'd0, res_valid}, 32'd1);
        check("fresh_res_data", res_data, 32'h55AA);
        check("fresh_res_err", {31'd0, res_err}, 32'd0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("fresh_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/snax_csr_initiator.md
SNAX_CSR_INITIATOR -- requirements
Module: snax_csr_initiator

Interface
REQ-001 SHALL have parameter RegDataWidth, default 32, CSR data width.
REQ-002 SHALL have parameter RegAddrWidth, default 32, CSR address width.
REQ-003 SHALL have parameter TimeoutWidth, default 16, poll attempt counter width.
REQ-004 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cmd_valid_i / cmd_ready_o  in/out  1/1  command handshake.
REQ-007 SHALL have port cmd_op_i  input  2  op: 0 write, 1 read, 2 poll, 3 illegal.
REQ-008 SHALL have ports cmd_addr_i / cmd_data_i / cmd_mask_i  input  RegAddrWidth / RegDataWidth / RegDataWidth  target address; write data or poll expected value; poll compare mask.
REQ-009 SHALL have port cmd_timeout_i  input  TimeoutWidth  extra poll attempts allowed.
REQ-010 SHALL have ports res_valid_o / res_ready_i  out/in  1/1  result handshake.
REQ-011 SHALL have ports res_data_o / res_err_o  output  RegDataWidth / 1  read data; error flag.
REQ-012 SHALL have ports snax_req_addr_o / snax_req_data_o / snax_req_write_o / snax_req_valid_o / snax_req_ready_i  out,out,out,out,in  RegAddrWidth,RegDataWidth,1,1,1  CSR request channel.
REQ-013 SHALL have ports snax_rsp_valid_i / snax_rsp_ready_o / snax_rsp_data_i  in,out,in  1,1,RegDataWidth  CSR read-response channel.
REQ-014 SHALL have port busy_o  output  1  high whenever state != IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, WAIT_RSP, RESULT; all outputs registered or decoded from state only.
REQ-016 SHALL assert cmd_ready_o iff state == IDLE; command captured on cmd_valid_i && cmd_ready_o.
REQ-017 SHALL on accepted op 0/1/2 go IDLE->REQ, asserting snax_req_valid_o the cycle after acceptance.
REQ-018 SHALL hold snax_req_addr/data/write stable while snax_req_valid_o high and not ready (AXI-style, no withdrawal).
REQ-019 SHALL drive snax_req_write_o=1, data=cmd_data for op 0; write_o=0, data=0 for ops 1/2.
REQ-020 SHALL, for op 0, return REQ->IDLE on request handshake; writes produce no result and expect no response.
REQ-021 SHALL, for ops 1/2, go REQ->WAIT_RSP on request handshake; snax_rsp_ready_o high only in WAIT_RSP.
REQ-022 SHALL, for op 1, on response handshake capture snax_rsp_data_i into res_data_o, res_err_o=0, go RESULT.
REQ-023 SHALL, for op 2, compare (rsp_data & mask) == (cmd_data & mask): match -> RESULT, err=0, data=rsp_data.
REQ-024 SHALL, for op 2 mismatch with attempt counter < cmd_timeout, increment counter and re-enter REQ next cycle (re-issue same read).
REQ-025 SHALL, for op 2 mismatch with counter == cmd_timeout, go RESULT with err=1, data=last rsp_data; total reads = cmd_timeout+1.
REQ-026 SHALL clear attempt counter on command acceptance; counter never wraps.
REQ-027 SHALL, for op 3, go IDLE->RESULT directly, err=1, data=0, no CSR request issued.
REQ-028 SHALL hold res_valid_o, res_data_o, res_err_o stable in RESULT until res_ready_i; then go IDLE.
REQ-029 SHALL not accept a new command in the cycle res handshake completes (cmd_ready_o asserts one cycle later).
REQ-030 SHALL ignore snax_rsp_valid_i outside WAIT_RSP (not consumed, no state change).
REQ-031 SHALL minimum read latency: accept N, req valid N+1, rsp at N+2 if ready_i and rsp_valid_i immediate, res_valid_o N+3.

Reset
REQ-032 SHALL on rst_ni low immediately force state IDLE, counter 0, all valid/ready outputs 0, res_data_o 0, res_err_o 0, busy_o 0, snax_req_* 0.
REQ-033 SHALL abandon any in-flight transaction on mid-operation reset; no pending response is tracked afterward.
REQ-034 SHALL assert cmd_ready_o the first clock edge after rst_ni deasserts.

Verification
REQ-035 Write: op0 addr 0x3 data 0xA5A5, req_ready_i high -> one req cycle with write=1 addr 0x3 data 0xA5A5, no res_valid_o, cmd_ready_o back next cycle.
REQ-036 Read with backpressure: op1 addr 0xC, req_ready_i low 3 cycles, rsp 0x1234 -> req fields stable 4 cycles, res_data 0x1234, err 0.
REQ-037 Poll success: op2 mask 0x1 expected 0x1 timeout 5, responses 0x0,0x0,0x3 -> exactly 3 reads, res_data 0x3, err 0.
REQ-038 Poll timeout: op2 mask 0xF expected 0x8 timeout 2, responses always 0x0 -> exactly 3 reads, err 1, res_data 0x0.
REQ-039 Illegal op3 and res_ready_i low 4 cycles -> no snax_req_valid_o, res_valid_o held with err 1 until ready.
REQ-040 Reset in WAIT_RSP of a poll -> all outputs 0 asynchronously; after release a fresh op1 completes normally.
